// File: rtl/ac97_pkg.sv
// Shared AC97 frame geometry used by the uplink deframer (and the downlink framer).
package ac97_pkg;

  localparam int AC97_TAG_BITS   = 16;
  localparam int AC97_SLOT_BITS  = 20;
  localparam int AC97_FRAME_BITS = 256;

  // Frame bit index at which each payload slot starts (MSB first on the wire).
  localparam logic [7:0] AC97_ADDR_START   = 8'd16;
  localparam logic [7:0] AC97_DATA_START   = 8'd36;
  localparam logic [7:0] AC97_LEFT_START   = 8'd56;
  localparam logic [7:0] AC97_RIGHT_START  = 8'd76;
  localparam logic [7:0] AC97_LAST_PAYLOAD = 8'd95;

  // Tag bit positions, counted as frame bit indices (0 = first bit after SYNC).
  localparam int AC97_TAG_FRAME_VALID = 0;
  localparam int AC97_TAG_ADDR_VALID  = 1;
  localparam int AC97_TAG_DATA_VALID  = 2;
  localparam int AC97_TAG_LEFT_VALID  = 3;
  localparam int AC97_TAG_RIGHT_VALID = 4;

  // Receive FSM: HUNT waits for a SYNC rising edge, RECEIVE tracks the frame.
  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_RECEIVE = 1'b1
  } ac97_state_t;

  // True when frame bit index idx falls inside [start, start+width).
  function automatic logic in_slot(input logic [7:0] idx, input logic [7:0] start,
                                   input int width);
    logic [8:0] stop;
    stop = {1'b0, start} + 9'(width);
    return (idx >= start) && ({1'b0, idx} < stop);
  endfunction

endpackage

// File: rtl/ac97_deframer_shift.sv
// MSB-first serial-in/parallel-out shift register with load enable.
module ac97_deframer_shift #(
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] r_word;

  // Shift the new bit in at the LSB so the first received bit ends up at the MSB.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_word <= '0;
    else if (i_load) r_word <= {r_word[WIDTH-2:0], i_bit};
  end

  assign o_word = r_word;

endmodule

// File: rtl/ac97_deframer.sv
// AC97 uplink deframer: parses tag slot 0 and slots 1-4 from SDATA_IN into words.
// Input handshake: a bit is consumed on every cycle where up_stb & en is high;
// there is no back-pressure. Output: slot words/valids update together and
// next_frame pulses for exactly one cycle on the cycle after the bit-95 sample.
module ac97_deframer
  import ac97_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        up_stb,
  input  logic        up_sync,
  input  logic        up_data,
  input  logic        en,
  output logic        next_frame,
  output logic        sync_error,
  output logic        frame_valid,
  output logic        addr_valid,
  output logic [19:0] addr,
  output logic        data_valid,
  output logic [19:0] data,
  output logic        pcmleft_valid,
  output logic [19:0] pcmleft,
  output logic        pcmright_valid,
  output logic [19:0] pcmright,
  output logic        dbg_state
);

  ac97_state_t r_state, w_state_next;
  logic [7:0]  r_cnt, w_idx;
  logic        r_prev_sync;
  logic        w_sample, w_edge, w_store, w_err, w_commit;
  logic [15:0] w_tag;
  logic [19:0] w_addr, w_data, w_left, w_right;

  logic        r_next_frame, r_sync_error;
  logic [4:0]  r_valids;
  logic [19:0] r_addr, r_data, r_left, r_right;

  assign w_sample = up_stb & en;
  assign w_edge   = w_sample & up_sync & ~r_prev_sync;

  // Next state plus per-sample control: which frame index this bit is, whether it is stored.
  always_comb begin
    w_state_next = r_state;
    w_store      = 1'b0;
    w_err        = 1'b0;
    w_idx        = w_edge ? 8'd0 : r_cnt;
    case (r_state)
      ST_HUNT: begin
        if (w_edge) begin
          w_store      = 1'b1;
          w_state_next = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (w_edge) begin
          // A sync edge anywhere but the wrap point restarts the frame early.
          w_store = 1'b1;
          w_err   = (r_cnt != 8'd0);
        end else if (w_sample) begin
          if (r_cnt == 8'd0) begin
            // Frame boundary reached without SYNC: lose lock, do not capture.
            w_err        = 1'b1;
            w_state_next = ST_HUNT;
          end else begin
            w_store = 1'b1;
          end
        end
      end
      default: w_state_next = ST_HUNT;
    endcase
    if (!en) w_state_next = ST_HUNT;
  end

  assign w_commit = w_store & (w_idx == AC97_LAST_PAYLOAD);

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_HUNT;
    else         r_state <= w_state_next;
  end

  // Bit counter: the stored bit's index plus one, wrapping 255 -> 0.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)      r_cnt <= 8'd0;
    else if (w_store) r_cnt <= w_idx + 8'd1;
  end

  // Previous SYNC level seen on a sample; cleared while disabled so relock needs a fresh edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) r_prev_sync <= 1'b0;
    else if (w_sample)  r_prev_sync <= up_sync;
  end

  ac97_deframer_shift #(.WIDTH(AC97_TAG_BITS)) u_tag (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_bit(up_data), .o_word(w_tag),
    .i_load(w_store & (w_idx < 8'(AC97_TAG_BITS))));
  ac97_deframer_shift #(.WIDTH(AC97_SLOT_BITS)) u_addr (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_bit(up_data), .o_word(w_addr),
    .i_load(w_store & in_slot(w_idx, AC97_ADDR_START, AC97_SLOT_BITS)));
  ac97_deframer_shift #(.WIDTH(AC97_SLOT_BITS)) u_data (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_bit(up_data), .o_word(w_data),
    .i_load(w_store & in_slot(w_idx, AC97_DATA_START, AC97_SLOT_BITS)));
  ac97_deframer_shift #(.WIDTH(AC97_SLOT_BITS)) u_left (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_bit(up_data), .o_word(w_left),
    .i_load(w_store & in_slot(w_idx, AC97_LEFT_START, AC97_SLOT_BITS)));
  ac97_deframer_shift #(.WIDTH(AC97_SLOT_BITS)) u_right (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_bit(up_data), .o_word(w_right),
    .i_load(w_store & in_slot(w_idx, AC97_RIGHT_START, AC97_SLOT_BITS)));

  // One-cycle status pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_next_frame <= 1'b0;
      r_sync_error <= 1'b0;
    end else begin
      r_next_frame <= w_commit;
      r_sync_error <= w_err;
    end
  end

  // Commit: bit 95 is still on up_data, so pcmright takes it directly alongside the shifted bits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_valids <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_left   <= '0;
      r_right  <= '0;
    end else if (w_commit) begin
      r_valids[0] <= w_tag[AC97_TAG_BITS-1-AC97_TAG_FRAME_VALID];
      r_valids[1] <= w_tag[AC97_TAG_BITS-1-AC97_TAG_ADDR_VALID]  & w_tag[AC97_TAG_BITS-1-AC97_TAG_FRAME_VALID];
      r_valids[2] <= w_tag[AC97_TAG_BITS-1-AC97_TAG_DATA_VALID]  & w_tag[AC97_TAG_BITS-1-AC97_TAG_FRAME_VALID];
      r_valids[3] <= w_tag[AC97_TAG_BITS-1-AC97_TAG_LEFT_VALID]  & w_tag[AC97_TAG_BITS-1-AC97_TAG_FRAME_VALID];
      r_valids[4] <= w_tag[AC97_TAG_BITS-1-AC97_TAG_RIGHT_VALID] & w_tag[AC97_TAG_BITS-1-AC97_TAG_FRAME_VALID];
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_left      <= w_left;
      r_right     <= {w_right[AC97_SLOT_BITS-2:0], up_data};
    end
  end

  assign next_frame     = r_next_frame;
  assign sync_error     = r_sync_error;
  assign frame_valid    = r_valids[0];
  assign addr_valid     = r_valids[1];
  assign data_valid     = r_valids[2];
  assign pcmleft_valid  = r_valids[3];
  assign pcmright_valid = r_valids[4];
  assign addr           = r_addr;
  assign data           = r_data;
  assign pcmleft        = r_left;
  assign pcmright       = r_right;
  assign dbg_state      = r_state;

endmodule

// File: doc/ac97_deframer.md
Name: ac97_deframer

Overview:
Uplink counterpart of the AC97 downlink framer. It receives the codec's serial SDATA_IN bitstream (one bit per transceiver strobe, 256-bit frames marked by SYNC) and parses tag slot 0 plus slots 1–4 into parallel words. It sits between the AC97 transceiver (up_* side) and the AC97 controller/DMA logic, which consumes the words on a one-cycle next_frame pulse.

Parameters:
none (frame geometry is fixed by AC97: 256 bits, 16-bit tag, 20-bit slots).

Ports:
sys_clk  in  1  system clock, sole clock domain
sys_rst  in  1  synchronous reset, active-high
up_stb  in  1  transceiver has one new received bit this cycle
up_sync  in  1  SYNC level accompanying this bit
up_data  in  1  SDATA_IN bit accompanying this bit
en  in  1  enable; when 0, strobes are ignored and the block returns to HUNT
next_frame  out  1  one-cycle pulse: slot outputs just updated
sync_error  out  1  one-cycle pulse: SYNC edge missing or misplaced
frame_valid  out  1  tag bit 15 (frame valid) of last committed frame
addr_valid  out  1  tag slot-1 valid, qualified by frame valid
addr  out  20  slot 1 (status address)
data_valid  out  1  tag slot-2 valid, qualified
data  out  20  slot 2 (status data)
pcmleft_valid  out  1  tag slot-3 valid, qualified
pcmleft  out  20  slot 3 PCM left
pcmright_valid  out  1  tag slot-4 valid, qualified
pcmright  out  20  slot 4 PCM right

Behaviour:
- Reset: all outputs 0. State is HUNT, bit counter is 0, prev_sync is 0, and the shift registers are 0.
- A sample is a cycle with up_stb & en. Nothing advances on any other cycle. prev_sync updates only on samples.
- A sync edge is a sample with up_sync=1 and prev_sync=0. The bit in that sample is frame bit index 0.
- HUNT:
  - Sample without sync edge: ignored.
  - Sync edge: capture bit 0, counter <= 1, go to RECEIVE.
- RECEIVE: each sample stores its bit by counter value, MSB first.
  - 0..15: tag.
  - 16..35: addr.
  - 36..55: data.
  - 56..75: pcmleft.
  - 76..95: pcmright.
  - 96..255: discarded.
  - Counter is 8 bits and wraps 255->0.
- Commit occurs on the sample with counter=95, at the same edge that stores bit 95.
  - All slot outputs and valid flags update together.
  - next_frame is 1 in the following cycle only.
  - Outputs hold until the next commit.
- Valid flags (index = frame bit index):
  - frame_valid = tag bit 0.
  - addr_valid = bit1 & bit0.
  - data_valid = bit2 & bit0.
  - pcmleft_valid = bit3 & bit0.
  - pcmright_valid = bit4 & bit0.
- Payload words are committed regardless of the valid flags.
- Sync checking in RECEIVE:
  - Sync edge when counter=0 (i.e. after wrap): normal start of the next frame.
  - Sync edge at any other counter value: pulse sync_error. Treat the sample as bit 0 of a new frame (counter <= 1). A partial frame with counter < 95 is dropped with no commit.
  - Sample at counter=0 with no sync edge: pulse sync_error and go to HUNT. This sample is not captured.
- A sync level held high across a frame does not generate a second edge.
- en=0: go to HUNT, clear prev_sync, hold all outputs. A pending next_frame/sync_error pulse still completes its single cycle.
- Reset mid-frame returns to reset values immediately. No commit happens for the partial frame.
- Throughput: up_stb may be asserted every cycle. Commit latency is 1 cycle after the bit-95 sample.

Decomposition:
- Shared ac97 package:
  - Constants: AC97_TAG_BITS=16, AC97_SLOT_BITS=20, AC97_FRAME_BITS=256.
  - Slot start indices: 16/36/56/76; last payload index 95.
  - Tag bit positions 0..4.
  - The same constants serve the framer.
- No sub-module is needed; one FSM (HUNT/RECEIVE) plus a counter and shift registers. A small ac97_slot_shift (20-bit MSB-first shift register with load enable) is optional and natural if shared with future slots.

Test Plan:
- Nominal frame: sync edge, tag 1_1111_0..., addr=0x26000, data=0x0F0F0, left=0x12345, right=0xABCDE -> one next_frame pulse one cycle after bit 95. All five valids are 1 and the words match exactly.
- Frame-valid clear: tag bit0=0, bits1-4=1 -> frame_valid=0 and all slot valids=0. Words are still updated.
- Back-to-back frames with up_stb every cycle, three frames with distinct data -> exactly 3 next_frame pulses spaced 256 cycles apart, each holding the correct words.
- Early sync edge at counter=50 -> sync_error pulse, no commit for the aborted frame. The restarted frame commits correctly at its own bit 95.
- Missing sync at wrap (sync held 0) -> sync_error pulse at the counter=0 sample and return to HUNT. No further next_frame until the next sync edge.
- en deasserted mid-frame (bit 40) then reasserted -> outputs hold their previous values and there is no commit. The block relocks on the next sync edge and commits the next full frame.
